// File: rtl/lstm_pkg.sv
// Shared state encoding and derived timing constants for the LSTM forward sequencer.
// Consumers derive MAC_LEN / CELL_CYCLES from their own parameters through these helpers.
package lstm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic int mac_len(input int num_input, input int num_cell);
    return num_input + num_cell;
  endfunction

  function automatic int cell_cycles(input int num_input, input int num_cell, input int delay);
    return mac_len(num_input, num_cell) + delay + 2;
  endfunction

endpackage

// File: rtl/lstm_seq_cnt.sv
// Loadable up-counter with enable; tc flags the terminal value LAST.
// Load has priority over enable; the count wraps freely past LAST.
module lstm_seq_cnt #(
  parameter int               WIDTH = 12,
  parameter logic [WIDTH-1:0] LAST  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (en) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/lstm_fwd_seq.sv
// LSTM layer forward sequencer: per cell LOAD -> MAC -> DRAIN -> WRITE, walking cell then timestep.
// i_hold freezes all state and masks strobes; H/C results land one timestep up (slot t=-1 is zero).
module lstm_fwd_seq
  import lstm_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMESTEP   = 7,
  parameter int NUM_CELL   = 8,
  parameter int NUM_INPUT  = 53,
  parameter int DELAY      = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_hold,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_en_addr,
  output logic                  o_acc_clr,
  output logic                  o_acc_en,
  output logic                  o_wr_en_h,
  output logic                  o_wr_en_c,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [ADDR_WIDTH-1:0] o_t,
  output logic [ADDR_WIDTH-1:0] o_cell
);

  localparam int MAC_LEN = mac_len(NUM_INPUT, NUM_CELL);

  if ((NUM_CELL * (TIMESTEP + 1) - 1) >= (1 << ADDR_WIDTH) ||
      (MAC_LEN - 1) >= (1 << ADDR_WIDTH) || (DELAY - 1) >= (1 << ADDR_WIDTH)) begin : g_width_chk
    $error("lstm_fwd_seq: ADDR_WIDTH too small for NUM_CELL*(TIMESTEP+1) addresses or counters");
  end

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] k_cnt, d_cnt, cell_cnt, t_cnt, addr_q;
  logic                  k_tc, d_tc, cell_tc, t_tc;
  logic                  start_go, wr_go;

  assign start_go = (state_q == ST_IDLE) && i_start && !i_hold;
  assign wr_go    = (state_q == ST_WRITE) && !i_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_MAC;
      ST_MAC:   if (k_tc) state_d = ST_DRAIN;
      ST_DRAIN: if (d_tc) state_d = ST_WRITE;
      ST_WRITE: state_d = (cell_tc && t_tc) ? ST_DONE : ST_LOAD;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (i_hold) state_d = state_q;
  end

  lstm_seq_cnt #(.WIDTH(ADDR_WIDTH), .LAST(ADDR_WIDTH'(MAC_LEN - 1))) u_k_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     ((state_q == ST_LOAD) && !i_hold),
    .ld_val ('0),
    .en     ((state_q == ST_MAC) && !i_hold),
    .cnt    (k_cnt),
    .tc     (k_tc)
  );

  lstm_seq_cnt #(.WIDTH(ADDR_WIDTH), .LAST(ADDR_WIDTH'(DELAY - 1))) u_d_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     ((state_q == ST_MAC) && k_tc && !i_hold),
    .ld_val ('0),
    .en     ((state_q == ST_DRAIN) && !i_hold),
    .cnt    (d_cnt),
    .tc     (d_tc)
  );

  // cell wraps to 0 and t advances on the last cell; both freeze on the final write
  lstm_seq_cnt #(.WIDTH(ADDR_WIDTH), .LAST(ADDR_WIDTH'(NUM_CELL - 1))) u_cell_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (start_go || (wr_go && cell_tc && !t_tc)),
    .ld_val ('0),
    .en     (wr_go && !cell_tc),
    .cnt    (cell_cnt),
    .tc     (cell_tc)
  );

  lstm_seq_cnt #(.WIDTH(ADDR_WIDTH), .LAST(ADDR_WIDTH'(TIMESTEP - 1))) u_t_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (start_go),
    .ld_val ('0),
    .en     (wr_go && cell_tc && !t_tc),
    .cnt    (t_cnt),
    .tc     (t_tc)
  );

  // Tracks (t+1)*NUM_CELL + cell incrementally instead of multiplying
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (start_go) begin
      addr_q <= ADDR_WIDTH'(NUM_CELL);
    end else if (wr_go) begin
      addr_q <= addr_q + ADDR_WIDTH'(1);
    end
  end

  assign o_busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_done    = (state_q == ST_DONE);
  assign o_en_addr = ((state_q == ST_LOAD) || (state_q == ST_MAC) || (state_q == ST_DRAIN)) && !i_hold;
  assign o_acc_clr = (state_q == ST_LOAD) && !i_hold;
  assign o_acc_en  = (state_q == ST_MAC) && !i_hold;
  assign o_wr_en_h = wr_go;
  assign o_wr_en_c = wr_go;
  assign o_wr_addr = wr_go ? addr_q : '0;
  assign o_t       = t_cnt;
  assign o_cell    = cell_cnt;

endmodule

// File: tb/tb_lstm_fwd_seq.sv
// Directed bench: small-parameter instance for cycle-exact scenarios, default instance for full-run addressing.
module tb_lstm_fwd_seq;

  localparam int AW   = 12;
  localparam int NCYC = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          s_rst_n, s_start, s_hold;
  logic          s_busy, s_done, s_en_addr, s_acc_clr, s_acc_en, s_wr_en_h, s_wr_en_c;
  logic [AW-1:0] s_wr_addr, s_t, s_cell;

  logic          d_rst_n, d_start, d_hold;
  logic          d_busy, d_done, d_en_addr, d_acc_clr, d_acc_en, d_wr_en_h, d_wr_en_c;
  logic [AW-1:0] d_wr_addr, d_t, d_cell;

  lstm_fwd_seq #(.ADDR_WIDTH(AW), .TIMESTEP(2), .NUM_CELL(2), .NUM_INPUT(3), .DELAY(4)) dut_s (
    .clk(clk), .rst_n(s_rst_n), .i_start(s_start), .i_hold(s_hold),
    .o_busy(s_busy), .o_done(s_done), .o_en_addr(s_en_addr), .o_acc_clr(s_acc_clr),
    .o_acc_en(s_acc_en), .o_wr_en_h(s_wr_en_h), .o_wr_en_c(s_wr_en_c),
    .o_wr_addr(s_wr_addr), .o_t(s_t), .o_cell(s_cell)
  );

  lstm_fwd_seq #(.ADDR_WIDTH(AW)) dut_d (
    .clk(clk), .rst_n(d_rst_n), .i_start(d_start), .i_hold(d_hold),
    .o_busy(d_busy), .o_done(d_done), .o_en_addr(d_en_addr), .o_acc_clr(d_acc_clr),
    .o_acc_en(d_acc_en), .o_wr_en_h(d_wr_en_h), .o_wr_en_c(d_wr_en_c),
    .o_wr_addr(d_wr_addr), .o_t(d_t), .o_cell(d_cell)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected per-cycle behaviour of the small instance, filled by hand-placed cell windows
  bit exp_wr[NCYC], exp_clr[NCYC], exp_acc[NCYC], exp_ena[NCYC], exp_busy[NCYC], exp_done[NCYC];
  bit zero_tc[NCYC];
  int exp_addr[NCYC], exp_t[NCYC], exp_cl[NCYC];

  task automatic zero_range(input int a, input int b);
    for (int c = a; c <= b; c++) begin
      exp_wr[c] = 0; exp_clr[c] = 0; exp_acc[c] = 0; exp_ena[c] = 0;
      exp_busy[c] = 0; exp_done[c] = 0; zero_tc[c] = 0;
      exp_addr[c] = 0; exp_t[c] = 0; exp_cl[c] = 0;
    end
  endtask

  // s = LOAD cycle, w = write cycle; LOAD 1 + MAC 5 + DRAIN 4 gives en_addr for 10 cycles
  task automatic add_cell(input int s, input int w, input int a, input int t, input int cl);
    exp_clr[s] = 1;
    for (int c = s; c <= s + 9; c++) exp_ena[c] = 1;
    for (int c = s + 1; c <= s + 5; c++) exp_acc[c] = 1;
    for (int c = s; c <= w; c++) exp_busy[c] = 1;
    exp_wr[w] = 1; exp_addr[w] = a; exp_t[w] = t; exp_cl[w] = cl;
  endtask

  task automatic run_scn(input string nm, input int len, input int st2,
                         input int h0, input int hn, input int r0, input int rn);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      s_start = (c == 0) || (c == st2);
      s_hold  = (c >= h0) && (c < h0 + hn);
      s_rst_n = !((c >= r0) && (c < r0 + rn));
      #1;
      check($sformatf("%s c%0d wr_h", nm, c), s_wr_en_h, exp_wr[c]);
      check($sformatf("%s c%0d wr_c", nm, c), s_wr_en_c, exp_wr[c]);
      check($sformatf("%s c%0d wr_addr", nm, c), s_wr_addr, exp_addr[c]);
      check($sformatf("%s c%0d acc_clr", nm, c), s_acc_clr, exp_clr[c]);
      check($sformatf("%s c%0d acc_en", nm, c), s_acc_en, exp_acc[c]);
      check($sformatf("%s c%0d en_addr", nm, c), s_en_addr, exp_ena[c]);
      check($sformatf("%s c%0d busy", nm, c), s_busy, exp_busy[c]);
      check($sformatf("%s c%0d done", nm, c), s_done, exp_done[c]);
      if (exp_wr[c] || zero_tc[c]) begin
        check($sformatf("%s c%0d t", nm, c), s_t, exp_t[c]);
        check($sformatf("%s c%0d cell", nm, c), s_cell, exp_cl[c]);
      end
    end
    @(negedge clk);
    s_start = 0; s_hold = 0; s_rst_n = 1;
  endtask

  task automatic nominal_exp();
    zero_range(0, NCYC - 1);
    add_cell(1, 11, 2, 0, 0);
    add_cell(12, 22, 3, 0, 1);
    add_cell(23, 33, 4, 1, 0);
    add_cell(34, 44, 5, 1, 1);
    exp_done[45] = 1;
  endtask

  initial begin
    int nw;
    bit saw_done;
    s_rst_n = 0; s_start = 0; s_hold = 0;
    d_rst_n = 0; d_start = 0; d_hold = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst busy", s_busy, 0);
    check("rst wr_addr", s_wr_addr, 0);
    check("rst t", s_t, 0);
    check("rst cell", s_cell, 0);
    check("rst en_addr", s_en_addr, 0);
    s_rst_n = 1; d_rst_n = 1;
    repeat (2) @(negedge clk);

    nominal_exp();
    run_scn("nom", 50, -1, -1, 0, -1, 0);

    // hold across the first WRITE: write slips to cycle 14, everything after by +3
    zero_range(0, NCYC - 1);
    add_cell(1, 14, 2, 0, 0);
    add_cell(15, 25, 3, 0, 1);
    add_cell(26, 36, 4, 1, 0);
    add_cell(37, 47, 5, 1, 1);
    exp_done[48] = 1;
    run_scn("hold", 52, -1, 11, 3, -1, 0);

    nominal_exp();
    run_scn("restart", 50, 20, -1, 0, -1, 0);

    // reset during cell 1 MAC, new start at cycle 18
    zero_range(0, NCYC - 1);
    add_cell(1, 11, 2, 0, 0);
    add_cell(12, 22, 3, 0, 1);
    zero_range(15, 22);
    zero_tc[15] = 1; zero_tc[16] = 1;
    add_cell(19, 29, 2, 0, 0);
    add_cell(30, 40, 3, 0, 1);
    add_cell(41, 51, 4, 1, 0);
    add_cell(52, 62, 5, 1, 1);
    exp_done[63] = 1;
    run_scn("rst", 66, 18, -1, 0, 15, 2);

    // default parameters: 56 writes at 111-cycle spacing, done at 6217
    nw = 0; saw_done = 0;
    for (int c = 0; c < 6300; c++) begin
      @(negedge clk);
      d_start = (c == 0);
      #1;
      if (d_wr_en_h) begin
        check($sformatf("def wr%0d addr", nw), d_wr_addr, 8 + nw);
        check($sformatf("def wr%0d cycle", nw), c, 111 * (nw + 1));
        check($sformatf("def wr%0d wr_c", nw), d_wr_en_c, 1);
        nw++;
      end
      if (d_done) begin
        check("def done cycle", c, 6217);
        saw_done = 1;
      end
    end
    check("def write count", nw, 56);
    check("def done seen", saw_done, 1);
    check("def final t", d_t, 6);
    check("def final cell", d_cell, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
